// File: rtl/i2c_master_seq_writer.sv
// Buffered I2C write master: START, {DEV_ADDR,W}, reg_addr, n payload bytes, STOP.
// A NACK anywhere aborts the frame; it is replayed from the buffer up to MAX_RETRY times.
//
// state   | meaning
// IDLE    | bus idle, waiting for start
// LOAD    | accepting payload bytes into the buffer
// START   | START condition, 4 quarters
// SHIFT   | address, register and data bits plus ACK slots
// STOP    | STOP condition, 4 quarters
// GAP     | idle bus between a NACKed frame and its replay
// DONE    | one-cycle completion pulse
module i2c_master_seq_writer #(
  parameter logic [6:0] DEV_ADDR  = 7'h0A,
  parameter int         MAX_BYTES = 8,
  parameter int         CNT_W     = 4,
  parameter int         DIV       = 4,
  parameter int         MAX_RETRY = 2,
  parameter int         GAP_CYC   = 8
) (
  input  logic             clk_sda,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       reg_addr,
  input  logic [CNT_W-1:0] byte_cnt,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic             i2c_scl,
  output logic             i2c_sda_oe,
  input  logic             i2c_sda_i
);

  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_SHIFT, S_STOP, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_ADDR, PH_REG, PH_DATA} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [7:0]       reg_q, reg_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             nack_q, nack_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       buf_q [MAX_BYTES];
  logic [7:0]       buf_d [MAX_BYTES];

  logic             qtick, bit_end, last_byte, can_retry;
  logic [CNT_W-1:0] cnt_clamp;
  logic [7:0]       cur_byte;

  assign qtick     = (div_q == '0);
  assign bit_end   = qtick && (qtr_q == 2'd3);
  assign cnt_clamp = (byte_cnt > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : byte_cnt;
  assign last_byte = ((phase_q == PH_REG) && (n_q == '0)) ||
                     ((phase_q == PH_DATA) && (idx_q == n_q - CNT_W'(1)));
  assign can_retry = (retry_q < RTY_W'(MAX_RETRY));

  always_comb begin
    case (phase_q)
      PH_ADDR: cur_byte = {DEV_ADDR, 1'b0};
      PH_REG:  cur_byte = reg_q;
      default: cur_byte = buf_q[idx_q[IDX_W-1:0]];
    endcase
  end

  always_ff @(posedge clk_sda or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= PH_ADDR;
      div_q   <= DIV_W'(DIV - 1);
      qtr_q   <= 2'd0;
      bit_q   <= 3'd7;
      ack_q   <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
      reg_q   <= 8'h00;
      retry_q <= '0;
      nack_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      ack_q   <= ack_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      reg_q   <= reg_d;
      retry_q <= retry_d;
      nack_q  <= nack_d;
      gap_q   <= gap_d;
    end
  end

  // Payload storage needs no reset; it is always written before it is read.
  always_ff @(posedge clk_sda) begin
    buf_q <= buf_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (cnt_clamp == '0) ? S_START : S_LOAD;
      S_LOAD:  if (tx_valid && (idx_q == n_q - CNT_W'(1))) state_d = S_START;
      S_START: if (bit_end) state_d = S_SHIFT;
      S_SHIFT: if (bit_end && ack_q && (nack_q || last_byte)) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (!nack_q || !can_retry) state_d = S_DONE;
          else                       state_d = (GAP_CYC == 0) ? S_START : S_GAP;
        end
      end
      S_GAP:   if (gap_q == '0) state_d = S_START;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    div_d   = DIV_W'(DIV - 1);
    qtr_d   = 2'd0;
    bit_d   = bit_q;
    ack_d   = ack_q;
    idx_d   = idx_q;
    n_d     = n_q;
    reg_d   = reg_q;
    retry_d = retry_q;
    nack_d  = nack_q;
    gap_d   = gap_q;
    buf_d   = buf_q;

    // Quarter-period timer runs only while the bus is being clocked.
    if (state_q == S_START || state_q == S_SHIFT || state_q == S_STOP) begin
      qtr_d = qtick ? qtr_q + 2'd1 : qtr_q;
      div_d = qtick ? DIV_W'(DIV - 1) : div_q - DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          reg_d   = reg_addr;
          n_d     = cnt_clamp;
          retry_d = '0;
          idx_d   = '0;
          nack_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (tx_valid) begin
          buf_d[idx_q[IDX_W-1:0]] = tx_data;
          idx_d = (idx_q == n_q - CNT_W'(1)) ? '0 : idx_q + CNT_W'(1);
        end
      end
      S_START: begin
        if (bit_end) begin
          phase_d = PH_ADDR;
          bit_d   = 3'd7;
          ack_d   = 1'b0;
          idx_d   = '0;
          nack_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        if (ack_q && (qtr_q == 2'd1) && qtick) nack_d = i2c_sda_i;
        if (bit_end) begin
          if (!ack_q) begin
            if (bit_q == 3'd0) ack_d = 1'b1;
            else               bit_d = bit_q - 3'd1;
          end else begin
            ack_d = 1'b0;
            bit_d = 3'd7;
            if (!last_byte) begin
              case (phase_q)
                PH_ADDR: phase_d = PH_REG;
                PH_REG:  phase_d = PH_DATA;
                default: idx_d   = idx_q + CNT_W'(1);
              endcase
            end
          end
        end
      end
      S_STOP: begin
        if (bit_end && nack_q && can_retry) begin
          retry_d = retry_q + RTY_W'(1);
          gap_d   = GAP_W'(GAP_CYC - 1);
        end
      end
      S_GAP:   gap_d = gap_q - GAP_W'(1);
      default: ;
    endcase
  end

  always_comb begin
    tx_ready   = (state_q == S_LOAD);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    nack_err   = (state_q == S_DONE) && nack_q;
    i2c_scl    = 1'b1;
    i2c_sda_oe = 1'b0;
    case (state_q)
      S_START: i2c_sda_oe = qtr_q[1];
      S_SHIFT: begin
        i2c_scl    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        i2c_sda_oe = !ack_q && !cur_byte[bit_q];
      end
      S_STOP: begin
        i2c_scl    = (qtr_q != 2'd0);
        i2c_sda_oe = !qtr_q[1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_seq_writer.sv
// Bench for i2c_master_seq_writer: a bus-level slave/monitor decodes every frame and the
// expected frame list is derived from the byte count, payload and the slave's NACK plan.
`timescale 1ns/1ps
module tb_i2c_master_seq_writer;

  localparam logic [6:0] DEV_ADDR = 7'h0A;
  localparam int MAX_BYTES = 8;
  localparam int CNT_W     = 4;
  localparam int DIV       = 2;
  localparam int MAX_RETRY = 2;
  localparam int GAP_CYC   = 8;

  logic             clk_sda  = 1'b0;
  logic             rst_n    = 1'b0;
  logic             start    = 1'b0;
  logic [7:0]       reg_addr = 8'h00;
  logic [CNT_W-1:0] byte_cnt = '0;
  logic [7:0]       tx_data  = 8'h00;
  logic             tx_valid = 1'b0;
  logic             tx_ready, busy, done, nack_err, i2c_scl, i2c_sda_oe, i2c_sda_i;
  logic             slave_low = 1'b0;

  assign i2c_sda_i = !(i2c_sda_oe || slave_low);

  always #5 clk_sda = ~clk_sda;

  i2c_master_seq_writer #(
    .DEV_ADDR(DEV_ADDR), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W),
    .DIV(DIV), .MAX_RETRY(MAX_RETRY), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk_sda(clk_sda), .rst_n(rst_n), .start(start), .reg_addr(reg_addr),
    .byte_cnt(byte_cnt), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .nack_err(nack_err), .i2c_scl(i2c_scl),
    .i2c_sda_oe(i2c_sda_oe), .i2c_sda_i(i2c_sda_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_sda) cyc++;

  // Slave / bus monitor state
  logic [7:0] fr_byte [0:7][0:19];
  int         fr_len   [0:7];
  int         fr_start [0:7];
  int         fr_stop  [0:7];
  int         nack_pos [0:7];
  int         nfr = 0;
  bit         in_frame = 0;
  bit         p_scl = 1, p_sda = 1, m_scl, m_sda;
  int         bitn = 0, blen = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] data_tbl [0:15];

  always @(negedge clk_sda) begin
    if (!rst_n) begin
      in_frame  = 0;
      bitn      = 0;
      blen      = 0;
      slave_low = 1'b0;
      p_scl     = 1;
      p_sda     = 1;
    end else begin
      m_scl = i2c_scl;
      m_sda = i2c_sda_i;
      if (p_scl && m_scl && p_sda && !m_sda) begin
        in_frame = 1;
        bitn     = 0;
        blen     = 0;
        if (nfr < 8) fr_start[nfr] = cyc;
      end else if (p_scl && m_scl && !p_sda && m_sda && in_frame) begin
        if (nfr < 8) begin
          fr_stop[nfr] = cyc;
          fr_len[nfr]  = blen;
        end
        nfr++;
        in_frame = 0;
        bitn     = 0;
      end else if (!p_scl && m_scl && in_frame) begin
        bitn++;
        if (bitn <= 8) sh = {sh[6:0], m_sda};
        if (bitn == 9) begin
          if (nfr < 8 && blen < 20) fr_byte[nfr][blen] = sh;
          blen++;
          bitn = 0;
        end
      end else if (p_scl && !m_scl && in_frame) begin
        if (bitn == 8)      slave_low = (nfr < 8) ? (nack_pos[nfr] != blen) : 1'b1;
        else if (bitn == 0) slave_low = 1'b0;
      end
      p_scl = m_scl;
      p_sda = m_sda;
    end
  end

  task automatic do_write(input string tag, input logic [7:0] ra, input int cnt,
                          input bit poke_busy);
    logic [7:0] exp_b [0:9];
    int  exp_sent [0:7];
    int  n, exp_frames, t0, waited, k;
    bit  exp_err;
    n = (cnt > MAX_BYTES) ? MAX_BYTES : cnt;
    exp_b[0] = {DEV_ADDR, 1'b0};
    exp_b[1] = ra;
    for (int i = 0; i < n; i++) exp_b[i + 2] = data_tbl[i];
    exp_frames = 0;
    exp_err    = 0;
    for (int f = 0; f <= MAX_RETRY; f++) begin
      exp_frames++;
      if (nack_pos[f] >= 0 && nack_pos[f] < n + 2) begin
        exp_sent[f] = nack_pos[f] + 1;
        exp_err     = 1;
      end else begin
        exp_sent[f] = n + 2;
        exp_err     = 0;
        break;
      end
    end

    waited = 0;
    while (busy && waited < 100) begin
      @(negedge clk_sda);
      waited++;
    end
    nfr      = 0;
    start    = 1'b1;
    reg_addr = ra;
    byte_cnt = CNT_W'(cnt);
    @(negedge clk_sda);
    start    = 1'b0;
    reg_addr = 8'($urandom);
    byte_cnt = CNT_W'($urandom);
    check({tag, "_busy_rise"}, busy, 1);
    t0 = cyc;

    k = 0;
    waited = 0;
    while (k < n && waited < 2000) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = tx_valid ? data_tbl[k] : 8'($urandom);
      if (tx_valid && tx_ready) k++;
      @(negedge clk_sda);
      waited++;
    end
    tx_valid = 1'b0;
    if (n > 0) begin
      check({tag, "_load_cnt"}, k, n);
      check({tag, "_ready_drop"}, tx_ready, 0);
    end

    waited = 0;
    while (!done && waited < 20000) begin
      if (poke_busy && waited == 40) begin
        start    = 1'b1;
        reg_addr = ~ra;
        byte_cnt = CNT_W'(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk_sda);
      waited++;
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_nack_err"}, nack_err, exp_err);
    if (cnt == 0 && exp_frames == 1) check({tag, "_len_busy_done"}, cyc - t0, (8 + 36 * 2) * DIV);
    check({tag, "_frames"}, nfr, exp_frames);
    for (int f = 0; f < exp_frames && f < nfr && f < 8; f++) begin
      check($sformatf("%s_f%0d_nbytes", tag, f), fr_len[f], exp_sent[f]);
      for (int b = 0; b < exp_sent[f] && b < fr_len[f] && b < 20; b++)
        check($sformatf("%s_f%0d_b%0d", tag, f, b), fr_byte[f][b], exp_b[b]);
      check($sformatf("%s_f%0d_time", tag, f), fr_stop[f] - fr_start[f],
            (4 + 36 * exp_sent[f]) * DIV);
      if (f > 0)
        check($sformatf("%s_f%0d_gap", tag, f), fr_start[f] - fr_stop[f - 1],
              GAP_CYC + 4 * DIV);
    end
    @(negedge clk_sda);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    if (poke_busy) begin
      repeat (60) @(negedge clk_sda);
      check({tag, "_no_extra_busy"}, busy, 0);
      check({tag, "_no_extra_frame"}, nfr, exp_frames);
    end
  endtask

  task automatic clear_nacks();
    for (int i = 0; i < 8; i++) nack_pos[i] = -1;
  endtask

  initial begin
    int k, waited, cnt;
    clear_nacks();
    for (int i = 0; i < 16; i++) data_tbl[i] = 8'($urandom);
    repeat (3) @(negedge clk_sda);
    check("rst_scl", i2c_scl, 1);
    check("rst_oe", i2c_sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack_err", nack_err, 0);
    check("rst_ready", tx_ready, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sda);

    data_tbl[0] = 8'h50;
    do_write("single", 8'h05, 1, 0);

    data_tbl[0] = 8'h50; data_tbl[1] = 8'h48; data_tbl[2] = 8'h53;
    data_tbl[3] = 8'h47; data_tbl[4] = 8'h4E; data_tbl[5] = 8'h58;
    do_write("passcode", 8'h10, 6, 0);

    nack_pos[0] = 2; nack_pos[1] = 2; nack_pos[2] = 2; nack_pos[3] = 2;
    do_write("nack_data", 8'h20, 2, 0);
    clear_nacks();

    nack_pos[0] = 0;
    do_write("nack_then_ack", 8'h30, 3, 0);
    clear_nacks();

    do_write("zero_bytes", 8'h44, 0, 0);

    for (int i = 0; i < 16; i++) data_tbl[i] = 8'($urandom);
    do_write("clamp15", 8'h55, 15, 0);

    do_write("start_busy", 8'h66, 4, 1);

    // Reset in the middle of the payload, then a clean frame.
    nfr      = 0;
    start    = 1'b1;
    reg_addr = 8'h33;
    byte_cnt = CNT_W'(6);
    @(negedge clk_sda);
    start = 1'b0;
    k = 0;
    waited = 0;
    while (k < 6 && waited < 200) begin
      tx_valid = 1'b1;
      tx_data  = data_tbl[k];
      if (tx_ready) k++;
      @(negedge clk_sda);
      waited++;
    end
    tx_valid = 1'b0;
    waited = 0;
    while (!(in_frame && blen >= 3) && waited < 5000) begin
      @(negedge clk_sda);
      waited++;
    end
    check("mid_reached_data", (in_frame && blen >= 3), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_scl", i2c_scl, 1);
    check("mid_rst_oe", i2c_sda_oe, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", tx_ready, 0);
    repeat (3) @(negedge clk_sda);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sda);
    do_write("post_rst", 8'h77, 5, 0);

    for (int it = 0; it < 6; it++) begin
      cnt = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) data_tbl[i] = 8'($urandom);
      for (int f = 0; f < 8; f++)
        nack_pos[f] = ($urandom_range(0, 2) == 0) ?
                      $urandom_range(0, ((cnt > MAX_BYTES) ? MAX_BYTES : cnt) + 1) : -1;
      do_write($sformatf("rnd%0d", it), 8'($urandom), cnt, 0);
    end
    clear_nacks();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
